// File: rtl/scan_transfer_arbiter_if.sv
// Shared-link bundle between the two scanners and the transfer arbiter.
// The arbiter connects through the slave modport; the scanner side uses master.
interface scan_transfer_arbiter_if;
  logic [3:0] count_1;
  logic [3:0] count_2;
  logic       req_1;
  logic       req_2;
  logic       xfer_done;
  logic       grant_1;
  logic       grant_2;
  logic       wake_1;
  logic       wake_2;
  logic       flush_1;
  logic       flush_2;

  modport master (
    output count_1, count_2, req_1, req_2, xfer_done,
    input  grant_1, grant_2, wake_1, wake_2, flush_1, flush_2
  );

  modport slave (
    input  count_1, count_2, req_1, req_2, xfer_done,
    output grant_1, grant_2, wake_1, wake_2, flush_1, flush_2
  );
endinterface

// File: rtl/scan_transfer_arbiter.sv
// Round-robin owner of a shared transfer link for two scanners, with a
// per-grant watchdog, buffer flush pulses and partner-wake commands.
module scan_transfer_arbiter #(
  parameter int FULL_LEVEL   = 10,
  parameter int WAKE_LEVEL   = 8,
  parameter int XFER_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_system,
  scan_transfer_arbiter_if.slave  bus,
  output logic [2:0]              state,
  output logic                    timeout_err
);

  localparam int              TW         = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(XFER_TIMEOUT - 1);
  localparam logic [3:0]      FULL_L     = 4'(FULL_LEVEL);
  localparam logic [3:0]      WAKE_L     = 4'(WAKE_LEVEL);

  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_ARMED  = 3'b001,
    ST_GRANT1 = 3'b010,
    ST_GRANT2 = 3'b011
  } state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic           last2_reg, last2_next;   // 1: scanner 2 was served last
  logic           err_reg, err_next;
  logic [1:0]     flush_reg, flush_next;
  logic [1:0]     wake_reg, wake_next;

  logic [3:0]     count_vec [2];
  logic [3:0]     sat_vec   [2];
  logic [1:0]     req_vec;
  logic [1:0]     grant_vec;
  logic [1:0]     wake_vec;
  logic           cur_idx;

  assign count_vec[0] = bus.count_1;
  assign count_vec[1] = bus.count_2;
  assign req_vec      = {bus.req_2, bus.req_1};
  assign grant_vec    = {state_reg == ST_GRANT2, state_reg == ST_GRANT1};
  assign cur_idx      = (state_reg == ST_GRANT2);

  // Each scanner's wake is driven by its partner's saturated fill level.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_scanner
      assign sat_vec[gi]   = (count_vec[gi] > FULL_L) ? FULL_L : count_vec[gi];
      assign wake_next[gi] = (state_reg != ST_OFF) && (sat_vec[1-gi] >= WAKE_L);
      assign wake_vec[gi]  = wake_reg[gi] & ~grant_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_OFF;
      timer_reg <= '0;
      last2_reg <= 1'b1;
      err_reg   <= 1'b0;
      flush_reg <= 2'b00;
      wake_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      last2_reg <= last2_next;
      err_reg   <= err_next;
      flush_reg <= flush_next;
      wake_reg  <= wake_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    last2_next = last2_reg;
    err_next   = err_reg;
    flush_next = 2'b00;
    case (state_reg)
      ST_OFF: begin
        timer_next = '0;
        if (start_system) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        timer_next = '0;
        if (req_vec == 2'b11)   state_next = last2_reg ? ST_GRANT1 : ST_GRANT2;
        else if (req_vec[0])    state_next = ST_GRANT1;
        else if (req_vec[1])    state_next = ST_GRANT2;
      end
      ST_GRANT1, ST_GRANT2: begin
        if (bus.xfer_done) begin
          state_next          = ST_ARMED;
          timer_next          = '0;
          flush_next[cur_idx] = 1'b1;
          last2_next          = cur_idx;
        end else if (timer_reg == TIMER_LAST) begin
          state_next          = ST_ARMED;
          timer_next          = '0;
          flush_next[cur_idx] = 1'b1;
          last2_next          = cur_idx;
          err_next            = 1'b1;
        end else if (!req_vec[cur_idx]) begin
          // Requester withdrew: release the link without flushing its buffer.
          state_next = ST_ARMED;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = ST_OFF;
        timer_next = '0;
      end
    endcase
  end

  assign bus.grant_1  = grant_vec[0];
  assign bus.grant_2  = grant_vec[1];
  assign bus.wake_1   = wake_vec[0];
  assign bus.wake_2   = wake_vec[1];
  assign bus.flush_1  = flush_reg[0];
  assign bus.flush_2  = flush_reg[1];
  assign state        = state_reg;
  assign timeout_err  = err_reg;

endmodule

// File: tb/tb_scan_transfer_arbiter.sv
// Randomized and directed checks of scan_transfer_arbiter against a
// transaction-level reference model of ownership, timeouts and wakes.
module tb_scan_transfer_arbiter;
  localparam int FULL = 10;
  localparam int WAKE = 8;
  localparam int TMO  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_system = 1'b0;
  logic [2:0] state;
  logic       timeout_err;

  scan_transfer_arbiter_if bus();

  scan_transfer_arbiter #(
    .FULL_LEVEL  (FULL),
    .WAKE_LEVEL  (WAKE),
    .XFER_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_system(start_system),
    .bus         (bus),
    .state       (state),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: is the system enabled, who owns the link, how long.
  bit     m_on;
  int     m_owner;
  int     m_held;
  int     m_last;
  bit     m_err;
  bit [2:1] m_flush;
  bit [2:1] m_wake;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > FULL) ? FULL : x;
  endfunction

  task automatic model_reset();
    m_on = 0; m_owner = 0; m_held = 0; m_last = 2; m_err = 0;
    m_flush = '0; m_wake = '0;
  endtask

  task automatic model_step();
    bit w1, w2, req_own;
    if (!reset) begin
      model_reset();
      return;
    end
    w1 = m_on && (sat(int'(bus.count_2)) >= WAKE);
    w2 = m_on && (sat(int'(bus.count_1)) >= WAKE);
    m_flush = '0;
    if (!m_on) begin
      if (start_system) m_on = 1;
    end else if (m_owner == 0) begin
      if (bus.req_1 && bus.req_2) m_owner = (m_last == 2) ? 1 : 2;
      else if (bus.req_1)         m_owner = 1;
      else if (bus.req_2)         m_owner = 2;
      m_held = 0;
    end else begin
      req_own = (m_owner == 1) ? bus.req_1 : bus.req_2;
      if (bus.xfer_done) begin
        m_flush[m_owner] = 1; m_last = m_owner; m_owner = 0;
      end else if (m_held == TMO - 1) begin
        m_flush[m_owner] = 1; m_last = m_owner; m_owner = 0; m_err = 1;
      end else if (!req_own) begin
        m_owner = 0;
      end else begin
        m_held++;
      end
    end
    m_wake[1] = w1;
    m_wake[2] = w2;
  endtask

  task automatic check_outputs();
    int exp_state;
    bit g1, g2;
    exp_state = !m_on ? 0 : (m_owner == 0 ? 1 : m_owner + 1);
    g1 = (m_owner == 1);
    g2 = (m_owner == 2);
    check("state",       state,        exp_state);
    check("grant_1",     bus.grant_1,  g1);
    check("grant_2",     bus.grant_2,  g2);
    check("wake_1",      bus.wake_1,   m_wake[1] && !g1);
    check("wake_2",      bus.wake_2,   m_wake[2] && !g2);
    check("flush_1",     bus.flush_1,  m_flush[1]);
    check("flush_2",     bus.flush_2,  m_flush[2]);
    check("timeout_err", timeout_err,  m_err);
  endtask

  task automatic cycle(input bit st, input bit r1, input bit r2, input bit dn,
                       input logic [3:0] c1, input logic [3:0] c2);
    @(negedge clk);
    start_system  = st;
    bus.req_1     = r1;
    bus.req_2     = r2;
    bus.xfer_done = dn;
    bus.count_1   = c1;
    bus.count_2   = c2;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    $display("[TB] cyc %0d rst=%b st=%b req=%b%b done=%b c=%0d/%0d -> state=%0d g=%b%b w=%b%b f=%b%b err=%b",
             cyc, reset, st, r1, r2, dn, c1, c2, state, bus.grant_1, bus.grant_2,
             bus.wake_1, bus.wake_2, bus.flush_1, bus.flush_2, timeout_err);
  endtask

  // Assert reset between edges and check the immediate effect.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_state", state, 0);
    check("async_grant", {bus.grant_1, bus.grant_2}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  bit       r1_rnd, r2_rnd;
  logic [3:0] c1_rnd, c2_rnd;

  initial begin
    bus.req_1 = 0; bus.req_2 = 0; bus.xfer_done = 0;
    bus.count_1 = 0; bus.count_2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_state", state, 0);
    reset = 1'b1;

    // Requests before start_system are ignored.
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    check("off_hold_state", state, 0);
    check("off_hold_grant", bus.grant_1, 0);

    cycle(1, 0, 0, 0, 0, 0);
    check("armed", state, 1);
    cycle(0, 1, 1, 0, 0, 0);
    check("first_grant_1", bus.grant_1, 1);
    cycle(0, 1, 1, 1, 0, 0);
    check("done_flush_1", bus.flush_1, 1);
    check("done_armed", state, 1);
    cycle(0, 1, 1, 0, 0, 0);
    check("rr_grant_2", bus.grant_2, 1);
    check("flush_1_once", bus.flush_1, 0);

    // xfer_done on the last permitted cycle completes normally.
    repeat (TMO - 1) cycle(0, 1, 1, 0, 0, 0);
    check("late_still_g2", state, 3);
    cycle(0, 1, 1, 1, 0, 0);
    check("late_done_state", state, 1);
    check("late_done_flush", bus.flush_2, 1);
    check("late_done_err", timeout_err, 0);

    // Grant held with no completion expires.
    cycle(0, 1, 1, 0, 0, 0);
    check("timeout_g1", state, 2);
    repeat (TMO) cycle(0, 1, 1, 0, 0, 0);
    check("timeout_state", state, 1);
    check("timeout_flush", bus.flush_1, 1);
    check("timeout_err", timeout_err, 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("timeout_sticky", timeout_err, 1);
    check("timeout_flush_once", bus.flush_1, 0);

    // Wake threshold with saturation.
    cycle(0, 0, 0, 0, 7, 0);
    check("wake2_at7", bus.wake_2, 0);
    cycle(0, 0, 0, 0, 8, 0);
    check("wake2_at8", bus.wake_2, 1);
    cycle(0, 0, 0, 0, 15, 0);
    check("wake2_at15", bus.wake_2, 1);
    check("wake1_partner", bus.wake_1, 0);
    cycle(0, 0, 0, 0, 7, 0);
    check("wake2_back7", bus.wake_2, 0);

    // Randomized traffic with occasional resets.
    r1_rnd = 0; r2_rnd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        async_reset();
        cycle(0, r1_rnd, r2_rnd, 0, 4'd9, 4'd9);
        reset = 1'b1;
      end
      if ($urandom_range(7) == 0) r1_rnd = ~r1_rnd;
      if ($urandom_range(7) == 0) r2_rnd = ~r2_rnd;
      c1_rnd = 4'($urandom_range(15));
      c2_rnd = 4'($urandom_range(15));
      cycle($urandom_range(19) == 0, r1_rnd, r2_rnd, $urandom_range(9) == 0, c1_rnd, c2_rnd);
    end

    // Reset in the middle of a scanner-2 transfer.
    async_reset();
    cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("pre_abort_g2", bus.grant_2, 1);
    async_reset();
    check("abort_grant_2", bus.grant_2, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("abort_no_flush", bus.flush_2, 0);
    reset = 1'b1;
    repeat (3) cycle(0, 0, 1, 1, 0, 0);
    check("abort_stays_off", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/scan_transfer_arbiter.md
SCAN_TRANSFER_ARBITER -- requirements
Module: scan_transfer_arbiter

Interface
REQ-001 Parameter FULL_LEVEL, default 10: buffer count treated as full; inputs above it saturate to it.
REQ-002 Parameter WAKE_LEVEL, default 8: partner-wake threshold on a scanner's buffer count.
REQ-003 Parameter XFER_TIMEOUT, default 15: max cycles a grant may stay open without xfer_done.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start_system  in  1  system enable pulse; leaves OFF.
REQ-007 count_1, count_2  in  4 each  buffer fill level of scanner 1 / 2.
REQ-008 req_1, req_2  in  1 each  level: scanner ready to transfer.
REQ-009 xfer_done  in  1  one-cycle pulse from the shared link: current transfer complete.
REQ-010 grant_1, grant_2  out  1 each  level: scanner owns the shared link.
REQ-011 wake_1, wake_2  out  1 each  level: command scanner to leave standby and start scanning.
REQ-012 flush_1, flush_2  out  1 each  one-cycle pulse: scanner clears its buffer.
REQ-013 state  out  3  current FSM encoding.
REQ-014 timeout_err  out  1  sticky: a grant expired.

Function
REQ-015 FSM states SHALL be OFF=000, ARMED=001, GRANT1=010, GRANT2=011; other codes unreachable, decode to OFF.
REQ-016 OFF -> ARMED on start_system=1; start_system SHALL be ignored in all other states.
REQ-017 ARMED with one request high -> GRANTn for that requester on the next edge (grant latency 1 cycle from req).
REQ-018 ARMED with req_1 and req_2 both high -> grant the scanner not served last (1-bit round-robin pointer; pointer resets to "last served = 2", so scanner 1 wins first).
REQ-019 grant_n SHALL be high exactly while state == GRANTn; grant_1 and grant_2 SHALL never be high together.
REQ-020 In GRANTn a timer SHALL count cycles from 0; it resets to 0 on every entry to GRANTn.
REQ-021 GRANTn with xfer_done=1 -> ARMED; flush_n pulses high the following cycle; pointer := n.
REQ-022 GRANTn with timer == XFER_TIMEOUT-1 and xfer_done=0 -> ARMED; flush_n pulses; timeout_err := 1; pointer := n.
REQ-023 xfer_done and timeout in the same cycle: xfer_done wins, timeout_err unchanged.
REQ-024 GRANTn with req_n dropped (and no xfer_done) -> ARMED, no flush, pointer unchanged.
REQ-025 xfer_done outside GRANT1/GRANT2 SHALL be ignored.
REQ-026 After leaving GRANTn, ARMED SHALL last at least one cycle before any new grant.
REQ-027 wake_2 SHALL be registered: next cycle = (state != OFF) and sat(count_1) >= WAKE_LEVEL; wake_1 symmetric on count_2.
REQ-028 wake_n SHALL be forced low while grant_n is high.
REQ-029 Count saturation: sat(x) = min(x, FULL_LEVEL); values 11-15 treated as 10.
REQ-030 timeout_err SHALL clear only on reset.

Reset
REQ-031 reset low SHALL immediately force state=OFF, all grants, wakes, flushes and timeout_err to 0, timer 0, pointer = last served 2.
REQ-032 Reset asserted mid-grant SHALL abort the transfer without a flush pulse; after release the block waits in OFF for start_system.

Verification
REQ-033 Reset release, req_1=1, no start_system -> state stays 000, grant_1=0.
REQ-034 start_system pulse, then req_1=req_2=1 -> grant_1 one cycle after ARMED; xfer_done -> flush_1 pulse, ARMED one cycle, then grant_2.
REQ-035 GRANT1, no xfer_done for 15 cycles -> back to 001, flush_1 one cycle, timeout_err=1 held until reset.
REQ-036 xfer_done coincident with timer == 14 -> normal completion, timeout_err stays 0.
REQ-037 ARMED, count_1 stepped 7->8->15->7 -> wake_2 goes 0->1 (1-cycle lag), stays 1 at 15, returns 0.
REQ-038 reset low during GRANT2 -> grant_2 falls asynchronously, no flush_2, state 000.
